// File: rtl/control_cycle_sequencer.sv
// Periodic control-cycle sequencer: snapshots encoders every period, divides the motor
// encoder by the gearbox ratio, combines with the output encoder and hands a state to the PID.
module control_cycle_sequencer #(
  parameter int unsigned PERIOD_CYCLES = 32000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [23:0] encoder0_position,
  input  logic signed [23:0] encoder1_position,
  input  logic signed [23:0] gearBoxRatio,
  input  logic        [7:0]  control_mode,
  input  logic               pid_ack,
  output logic               pid_req,
  output logic signed [23:0] displacement,
  output logic signed [23:0] motor_state,
  output logic               busy,
  output logic               overrun,
  output logic               div_zero,
  output logic        [15:0] cycle_count
);

  typedef enum logic [2:0] {StIdle, StSnap, StDiv, StCombine, StReq} state_e;

  localparam logic [15:0] LastCount = 16'(PERIOD_CYCLES - 1);

  state_e             state_q, state_d;
  logic        [15:0] period_q, period_d;
  logic signed [23:0] enc0_q, enc0_d;
  logic signed [23:0] enc1_q, enc1_d;
  logic signed [23:0] ratio_q, ratio_d;
  logic        [7:0]  mode_q, mode_d;
  logic        [23:0] rem_q, rem_d;
  logic        [23:0] quo_q, quo_d;
  logic        [4:0]  step_q, step_d;
  logic signed [23:0] disp_q, disp_d;
  logic signed [23:0] mstate_q, mstate_d;
  logic               overrun_q, overrun_d;
  logic               div_zero_q, div_zero_d;
  logic        [15:0] cycles_q, cycles_d;

  logic               tick;
  logic        [23:0] enc0_in_mag, ratio_mag;
  logic        [24:0] trial, diff;
  logic               trial_ge;
  logic signed [23:0] quot_s, disp_new, mstate_new;

  assign tick        = enable & (period_q == LastCount);
  assign enc0_in_mag = encoder0_position[23] ? (~encoder0_position + 24'd1) : encoder0_position;
  assign ratio_mag   = ratio_q[23] ? (~ratio_q + 24'd1) : ratio_q;

  // Restoring step: quo_q shifts dividend bits out of the top and quotient bits in at the bottom.
  assign trial    = {rem_q, quo_q[23]};
  assign diff     = trial - {1'b0, ratio_mag};
  assign trial_ge = ~diff[24];

  always_comb begin
    if (ratio_q == 24'sd0) begin
      quot_s = '0;
    end else if (enc0_q[23] ^ ratio_q[23]) begin
      quot_s = $signed(~quo_q + 24'd1);
    end else if (quo_q[23]) begin
      // Only reachable for -8388608 / -1.
      quot_s = 24'sh7FFFFF;
    end else begin
      quot_s = $signed(quo_q);
    end
  end

  assign disp_new = quot_s - (enc1_q >>> 3);

  always_comb begin
    unique case (mode_q)
      8'd0:    mstate_new = enc0_q;
      8'd1:    mstate_new = enc1_q;
      8'd2:    mstate_new = disp_new;
      default: mstate_new = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    period_d   = enable ? (tick ? 16'd0 : period_q + 16'd1) : 16'd0;
    enc0_d     = enc0_q;
    enc1_d     = enc1_q;
    ratio_d    = ratio_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    step_d     = step_q;
    disp_d     = disp_q;
    mstate_d   = mstate_q;
    div_zero_d = div_zero_q;
    cycles_d   = cycles_q;
    // Ticks are never queued; one landing on any busy cycle is only flagged.
    overrun_d  = overrun_q | (tick & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StSnap;
      end
      StSnap: begin
        enc0_d  = encoder0_position;
        enc1_d  = encoder1_position;
        ratio_d = gearBoxRatio;
        mode_d  = control_mode;
        quo_d   = enc0_in_mag;
        rem_d   = '0;
        step_d  = '0;
        state_d = StDiv;
      end
      StDiv: begin
        rem_d  = trial_ge ? diff[23:0] : trial[23:0];
        quo_d  = {quo_q[22:0], trial_ge};
        step_d = step_q + 5'd1;
        if (step_q == 5'd23) state_d = StCombine;
      end
      StCombine: begin
        disp_d   = disp_new;
        mstate_d = mstate_new;
        if (ratio_q == 24'sd0) div_zero_d = 1'b1;
        state_d  = StReq;
      end
      StReq: begin
        if (pid_ack) begin
          cycles_d = cycles_q + 16'd1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      period_q   <= '0;
      enc0_q     <= '0;
      enc1_q     <= '0;
      ratio_q    <= '0;
      mode_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      step_q     <= '0;
      disp_q     <= '0;
      mstate_q   <= '0;
      overrun_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      enc0_q     <= enc0_d;
      enc1_q     <= enc1_d;
      ratio_q    <= ratio_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      step_q     <= step_d;
      disp_q     <= disp_d;
      mstate_q   <= mstate_d;
      overrun_q  <= overrun_d;
      div_zero_q <= div_zero_d;
      cycles_q   <= cycles_d;
    end
  end

  assign pid_req      = (state_q == StReq);
  assign busy         = (state_q != StIdle);
  assign displacement = disp_q;
  assign motor_state  = mstate_q;
  assign overrun      = overrun_q;
  assign div_zero     = div_zero_q;
  assign cycle_count  = cycles_q;

endmodule

// File: tb/tb_control_cycle_sequencer.sv
// Bench for control_cycle_sequencer: directed and random control cycles compared against
// an arithmetic model of displacement, state selection, timing and sticky flags.
module tb_control_cycle_sequencer;

  localparam int P   = 32;
  localparam int Lat = 27;

  logic               CLK = 1'b0;
  logic               reset, enable, pid_ack;
  logic signed [23:0] enc0, enc1, ratio;
  logic        [7:0]  mode;
  logic               pid_req, busy, overrun, div_zero;
  logic signed [23:0] displacement, motor_state;
  logic        [15:0] cycle_count;

  control_cycle_sequencer #(.PERIOD_CYCLES(P)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .enable            (enable),
    .encoder0_position (enc0),
    .encoder1_position (enc1),
    .gearBoxRatio      (ratio),
    .control_mode      (mode),
    .pid_ack           (pid_ack),
    .pid_req           (pid_req),
    .displacement      (displacement),
    .motor_state       (motor_state),
    .busy              (busy),
    .overrun           (overrun),
    .div_zero          (div_zero),
    .cycle_count       (cycle_count)
  );

  always #5 CLK = ~CLK;

  // Cycles since reset release or enable rise; a tick lands whenever cyc % P == P-1.
  int cyc;
  always @(posedge CLK) begin
    if (reset || !enable) cyc <= 0;
    else                  cyc <= cyc + 1;
  end

  int          n_vec, n_err;
  logic [15:0] cc_exp;
  logic        dz_exp, ov_exp, vec_dz;
  logic [23:0] exp_disp, exp_ms;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output int at, output int n);
    at = -1;
    n  = 0;
    for (int i = 0; i < 4 * P + 64; i++) begin
      @(negedge CLK);
      n = i + 1;
      if (pid_req === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("req_timeout", {23'd0, pid_req}, 24'd1);
  endtask

  task automatic set_vec(input int e0, input int e1, input int r, input int m);
    longint q, fl, d;
    if (r == 0) q = 0;
    else        q = longint'(e0) / longint'(r);
    if (q > 8388607) q = 8388607;
    fl = (longint'(e1) - ((longint'(e1) % 8 + 8) % 8)) / 8;
    d  = q - fl;
    exp_disp = d[23:0];
    case (m)
      0:       exp_ms = e0[23:0];
      1:       exp_ms = e1[23:0];
      2:       exp_ms = d[23:0];
      default: exp_ms = 24'd0;
    endcase
    vec_dz = (r == 0);
    enc0   = e0[23:0];
    enc1   = e1[23:0];
    ratio  = r[23:0];
    mode   = m[7:0];
  endtask

  task automatic finish_vec(input int ack_delay, input bit over, input int exact_at,
                            input int exact_wait);
    int at, n, ph, exp_ph;
    exp_ph = (P - 1 + Lat) % P;
    wait_req(at, n);
    ph = at % P;
    if (exact_wait >= 0)    check("req_wait", n[23:0], exact_wait[23:0]);
    else if (exact_at >= 0) check("req_cycle", at[23:0], exact_at[23:0]);
    else                    check("req_phase", ph[23:0], exp_ph[23:0]);
    dz_exp = dz_exp | vec_dz;
    check("disp", displacement, exp_disp);
    check("mstate", motor_state, exp_ms);
    check("div_zero", {23'd0, div_zero}, {23'd0, dz_exp});
    check("overrun", {23'd0, overrun}, {23'd0, ov_exp});
    check("busy_req", {23'd0, busy}, 24'd1);
    if (over) begin
      for (int i = 0; i < 2 * P; i++) begin
        @(negedge CLK);
        check("hold_req", {23'd0, pid_req}, 24'd1);
        check("hold_disp", displacement, exp_disp);
        if (cyc % P == 1) break;
      end
      ov_exp = 1'b1;
      check("overrun_set", {23'd0, overrun}, 24'd1);
      check("hold_mstate", motor_state, exp_ms);
    end
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge CLK);
      check("wait_req", {23'd0, pid_req}, 24'd1);
      check("wait_mstate", motor_state, exp_ms);
    end
    pid_ack = 1'b1;
    @(negedge CLK);
    pid_ack = 1'b0;
    cc_exp++;
    check("cycle_count", {8'd0, cycle_count}, {8'd0, cc_exp});
    check("req_drop", {23'd0, pid_req}, 24'd0);
    check("idle", {23'd0, busy}, 24'd0);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * P; i++) begin
      if (cyc % P == P - 1) break;
      @(negedge CLK);
    end
  endtask

  task automatic check_cleared();
    check("rst_req", {23'd0, pid_req}, 24'd0);
    check("rst_busy", {23'd0, busy}, 24'd0);
    check("rst_ovr", {23'd0, overrun}, 24'd0);
    check("rst_dz", {23'd0, div_zero}, 24'd0);
    check("rst_disp", displacement, 24'd0);
    check("rst_ms", motor_state, 24'd0);
    check("rst_cc", {8'd0, cycle_count}, 24'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cc_exp  = '0;
    dz_exp  = 1'b0;
    ov_exp  = 1'b0;
    reset   = 1'b1;
    enable  = 1'b1;
    pid_ack = 1'b0;
    set_vec(800, 80, 4, 2);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    check_cleared();

    // First control cycle: tick at cycle P-1, request 27 cycles later.
    finish_vec(0, 1'b0, P - 1 + Lat, -1);

    set_vec(-7, -1, 2, 2);
    finish_vec(1, 1'b0, -1, -1);

    // Stray acks while idle and while busy must not count.
    set_vec(55, 800, 0, 0);
    pid_ack = 1'b1;
    @(negedge CLK);
    pid_ack = 1'b0;
    check("idle_ack", {8'd0, cycle_count}, {8'd0, cc_exp});
    for (int i = 0; i < 4 * P; i++) begin
      if (busy === 1'b1) break;
      @(negedge CLK);
    end
    check("stray_busy", {23'd0, busy}, 24'd1);
    pid_ack = 1'b1;
    @(negedge CLK);
    pid_ack = 1'b0;
    finish_vec(2, 1'b0, -1, -1);

    set_vec(-8388608, 0, -1, 2);
    finish_vec(0, 1'b0, -1, -1);

    for (int v = 0; v < 20; v++) begin
      int e0, e1, r, m;
      e0 = int'($urandom_range(16777215, 0)) - 8388608;
      e1 = int'($urandom_range(16777215, 0)) - 8388608;
      case ($urandom_range(3, 0))
        0:       r = 0;
        1:       r = int'($urandom_range(40, 0)) - 20;
        default: r = int'($urandom_range(16777215, 0)) - 8388608;
      endcase
      if ($urandom_range(1, 0) == 0) e0 = int'($urandom_range(20000, 0)) - 10000;
      m = int'($urandom_range(4, 0));
      set_vec(e0, e1, r, m);
      finish_vec(int'($urandom_range(3, 0)), 1'b0, -1, -1);
    end

    // Ack withheld across the next tick: flagged, request held, one ack counts once.
    set_vec(1000, 16, 3, 1);
    finish_vec(0, 1'b1, -1, -1);
    set_vec(-123457, 9999, 11, 2);
    finish_vec(0, 1'b0, -1, -1);

    // Enable dropped mid-sequence: the sequence still completes on time.
    set_vec(123456, -9, 7, 2);
    wait_tick();
    repeat (5) @(negedge CLK);
    enable = 1'b0;
    finish_vec(0, 1'b0, -1, 22);
    repeat (40) @(negedge CLK);
    check("dis_req", {23'd0, pid_req}, 24'd0);
    check("dis_busy", {23'd0, busy}, 24'd0);
    set_vec(-300, 64, -5, 3);
    enable = 1'b1;
    finish_vec(0, 1'b0, P - 1 + Lat, -1);

    // Reset pulse in the middle of the division.
    set_vec(5000, 40, -6, 2);
    wait_tick();
    repeat (10) @(negedge CLK);
    check("div_busy", {23'd0, busy}, 24'd1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    cc_exp = '0;
    dz_exp = 1'b0;
    ov_exp = 1'b0;
    check_cleared();
    finish_vec(0, 1'b0, P - 1 + Lat, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
